ysyx_23060077_scoreboard: RTL and testbench
===========================================

# ysyx_23060077_scoreboard

Register-dependency scoreboard and issue controller between the ID stage and the execute/LSU back end. Tracks outstanding register writes per architectural register; gates the ID-to-EX issue handshake on RAW hazards, counter saturation, pipeline flush and drain requests from FENCE/SYS instructions. Produces a busy flag for drain logic and a stall-cycle counter for performance reporting.

## Interface

- CNT_W, default 2: width of each per-register pending-write counter; max outstanding writes per register = 2^CNT_W − 1.
- STALL_W, default 32: width of the stall-cycle counter.

- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a decoded instruction.
- id_ready  output  1  scoreboard accepts issue this cycle (combinational).
- id_rs1 / id_rs2  input  5  source register addresses.
- id_rs1_use / id_rs2_use  input  1  instruction reads rs1 / rs2.
- id_rd  input  5  destination register address.
- id_rd_wen  input  1  instruction writes rd.
- id_drain  input  1  instruction must issue with no writes outstanding (FENCE, SYS class).
- flush  input  1  redirect in progress; blocks issue this cycle.
- wb_valid  input  1  one register write retires this cycle.
- wb_rd  input  5  register being written back.
- busy  output  1  any pending counter nonzero (registered-state derived).
- err  output  1  sticky: writeback seen for a register with count 0.
- stall_cycles  output  STALL_W  cycles with id_valid=1 and id_ready=0.

## Operation

- State: cnt[r], r = 1..31, CNT_W bits each. x0 is never tracked; any address 0 is treated as hazard-free and never counted.
- issue_fire = id_valid & id_ready.
- hazard_rsN = id_rsN_use & (id_rsN != 0) & (cnt[id_rsN] != 0) & ~bypass_rsN.
- rd_full = id_rd_wen & (id_rd != 0) & (cnt[id_rd] == all-ones).
- drain_block = id_drain & busy.
- id_ready = ~flush & ~hazard_rs1 & ~hazard_rs2 & ~rd_full & ~drain_block. id_ready does not depend on id_valid.
- Counter update per r: +1 if issue_fire & id_rd_wen & id_rd == r; −1 if wb_valid & wb_rd == r; both → unchanged.
- wb_valid with wb_rd == 0: ignored. wb_valid on cnt == 0 (and no same-cycle increment): counter stays 0, err sets and holds until reset.
- flush does not alter counters; already-issued instructions still retire through wb.
- stall_cycles increments when id_valid & ~id_ready, wraps at 2^STALL_W.
- WAW to the same rd is allowed up to saturation; back end retires in order.

## Timing

- Reset values: all cnt = 0, busy = 0, err = 0, stall_cycles = 0; id_ready = 1 unless flush or drain inputs block.
- Reset mid-operation clears all counters the following edge; in-flight writebacks after reset set err.
- id_ready: combinational from registered counters and same-cycle inputs, zero latency.
- Counter/busy update: one cycle; an instruction issued at edge N is visible as a hazard at cycle N+1.
- busy derived from registered counters only; a cycle containing the last wb still reads busy = 1.
- Simultaneous issue of rd = r and wb of r: net count unchanged; saturation check uses the pre-update count.

## Configuration

- YSYX_23060077_SB_BYPASS_EN defined: bypass_rsN = wb_valid & (wb_rd == id_rsN) & (cnt[id_rsN] == 1); a consumer issues in the same cycle its producer writes back, relying on WB-to-ID forwarding in the register file.
- Not defined: bypass_rsN = 0; the consumer issues one cycle after the writeback.
- drain_block is never bypassed in either build.

## Structure

- Shared define file ysyx_23060077_define.v gains: YSYX_23060077_REG_ADDR_W (5), YSYX_23060077_SB_CNT_W default, YSYX_23060077_SB_BYPASS_EN guard.
- Sub-module ysyx_23060077_sb_cnt: one saturating up/down counter with inc, dec, underflow-flag outputs; instantiated 31 times via generate.
- Hazard, ready and stall counter logic stays in the top module.

## Test plan

- Issue add x5 (rd_wen), next cycle id_rs1 = 5 with use = 1 → id_ready = 0 until wb_valid, wb_rd = 5; ready the same cycle with BYPASS_EN, one cycle later without.
- Issue three writes to x7 with CNT_W = 2, then a fourth → fourth blocked (rd_full); one wb of x7 → fourth issues next cycle.
- id_drain = 1 while cnt[x3] = 1 → id_ready = 0, stall_cycles increments each cycle; after x3 retires and busy = 0 → issue.
- Same-cycle issue rd = 9 and wb_rd = 9 with cnt[9] = 1 → cnt[9] stays 1, busy stays 1.
- wb_valid, wb_rd = 12 with cnt[12] = 0 → err = 1 and held; cnt[12] stays 0; reset → err = 0.
- id_rs1 = 0, rd = 0 instructions back-to-back, plus flush = 1 pulse → ready every cycle except the flush cycle; no counter changes.

Source files
------------

// File: rtl/ysyx_23060077_scoreboard_pkg.sv
// Shared constants and types for the register-dependency scoreboard.
// Build option: define YSYX_23060077_SB_BYPASS_EN for same-cycle WB-to-ID issue.
package ysyx_23060077_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int SB_CNT_W   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Address zero is architecturally hard-wired and never tracked.
    function automatic logic is_tracked(input reg_addr_t a);
        return a != '0;
    endfunction

endpackage

// File: rtl/ysyx_23060077_sb_if.sv
// ID-to-scoreboard issue handshake plus the writeback retire port.
interface ysyx_23060077_sb_if;
    import ysyx_23060077_scoreboard_pkg::*;

    logic      id_valid;
    logic      id_ready;
    reg_addr_t id_rs1;
    reg_addr_t id_rs2;
    logic      id_rs1_use;
    logic      id_rs2_use;
    reg_addr_t id_rd;
    logic      id_rd_wen;
    logic      id_drain;
    logic      wb_valid;
    reg_addr_t wb_rd;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use,
               id_rd, id_rd_wen, id_drain, wb_valid, wb_rd,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use,
               id_rd, id_rd_wen, id_drain, wb_valid, wb_rd,
        output id_ready
    );

endinterface

// File: rtl/ysyx_23060077_sb_cnt.sv
// One pending-write counter: saturating up/down, flags underflow attempts.
module ysyx_23060077_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             full,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt  = cnt_q;
    assign nz   = cnt_q != '0;
    assign full = cnt_q == '1;

    // Simultaneous inc and dec cancel; a lone dec at zero holds and reports.
    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        case ({inc, dec})
            2'b10: if (!full) cnt_d = cnt_q + CNT_W'(1);
            2'b01: begin
                if (cnt_q == '0) underflow = 1'b1;
                else             cnt_d     = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ysyx_23060077_scoreboard.sv
// RAW/WAW/drain issue gate between ID and the back end; one counter per GPR.
// Build option: YSYX_23060077_SB_BYPASS_EN lets a consumer issue alongside its producer's WB.
module ysyx_23060077_scoreboard
    import ysyx_23060077_scoreboard_pkg::*;
#(
    parameter int CNT_W   = SB_CNT_W,
    parameter int STALL_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    ysyx_23060077_sb_if.slave  sb,
    input  logic               flush,
    output logic               busy,
    output logic               err,
    output logic [STALL_W-1:0] stall_cycles
);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0] inc, dec, nz, full, uflow;
    logic issue_fire;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_x0
            assign inc[r]   = 1'b0;
            assign dec[r]   = 1'b0;
            assign cnt[r]   = '0;
            assign nz[r]    = 1'b0;
            assign full[r]  = 1'b0;
            assign uflow[r] = 1'b0;
        end else begin : g_gpr
            assign inc[r] = issue_fire & sb.id_rd_wen & (sb.id_rd == REG_ADDR_W'(r));
            assign dec[r] = sb.wb_valid & (sb.wb_rd == REG_ADDR_W'(r));
            ysyx_23060077_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clock     (clock),
                .reset     (reset),
                .inc       (inc[r]),
                .dec       (dec[r]),
                .cnt       (cnt[r]),
                .nz        (nz[r]),
                .full      (full[r]),
                .underflow (uflow[r])
            );
        end
    end

    logic [CNT_W-1:0] rs1_cnt, rs2_cnt;
    logic bypass_rs1, bypass_rs2, hazard_rs1, hazard_rs2, rd_full, drain_block;

    assign rs1_cnt = cnt[sb.id_rs1];
    assign rs2_cnt = cnt[sb.id_rs2];

`ifdef YSYX_23060077_SB_BYPASS_EN
    // Only the last outstanding write may be forwarded; older WAW writes still pend.
    assign bypass_rs1 = sb.wb_valid & (sb.wb_rd == sb.id_rs1) & (rs1_cnt == CNT_W'(1));
    assign bypass_rs2 = sb.wb_valid & (sb.wb_rd == sb.id_rs2) & (rs2_cnt == CNT_W'(1));
`else
    assign bypass_rs1 = 1'b0;
    assign bypass_rs2 = 1'b0;
`endif

    assign busy        = |nz;
    assign hazard_rs1  = sb.id_rs1_use & is_tracked(sb.id_rs1) & (rs1_cnt != '0) & ~bypass_rs1;
    assign hazard_rs2  = sb.id_rs2_use & is_tracked(sb.id_rs2) & (rs2_cnt != '0) & ~bypass_rs2;
    assign rd_full     = sb.id_rd_wen & is_tracked(sb.id_rd) & full[sb.id_rd];
    assign drain_block = sb.id_drain & busy;
    assign sb.id_ready = ~flush & ~hazard_rs1 & ~hazard_rs2 & ~rd_full & ~drain_block;
    assign issue_fire  = sb.id_valid & sb.id_ready;

    logic               err_q, err_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        err_d   = err_q | (|uflow);
        stall_d = stall_q;
        if (sb.id_valid && !sb.id_ready) stall_d = stall_q + STALL_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign err          = err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ysyx_23060077_scoreboard.sv
// Directed bench for the scoreboard (default build: no WB bypass).
module tb_ysyx_23060077_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        busy, err;
    logic [31:0] stall_cycles;
    int          n_chk = 0;
    int          n_fail = 0;

    ysyx_23060077_sb_if sb ();

    ysyx_23060077_scoreboard #(.CNT_W(2), .STALL_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .sb           (sb.slave),
        .flush        (flush),
        .busy         (busy),
        .err          (err),
        .stall_cycles (stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        sb.id_valid = 0; sb.id_rs1 = 0; sb.id_rs2 = 0; sb.id_rs1_use = 0; sb.id_rs2_use = 0;
        sb.id_rd = 0; sb.id_rd_wen = 0; sb.id_drain = 0; sb.wb_valid = 0; sb.wb_rd = 0;
        flush = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_ready", sb.id_ready, 1);

        // RAW on rs1: producer x5, consumer waits for WB, issues the cycle after.
        sb.id_valid = 1; sb.id_rd = 5; sb.id_rd_wen = 1;
        #1 chk("raw_prod_rdy", sb.id_ready, 1);
        tick();
        sb.id_rd_wen = 0; sb.id_rd = 0; sb.id_rs1 = 5; sb.id_rs1_use = 1;
        #1 chk("raw_blk", sb.id_ready, 0);
        chk("raw_busy", busy, 1);
        tick();
        sb.wb_valid = 1; sb.wb_rd = 5;
        #1 chk("raw_wb_nobypass", sb.id_ready, 0);
        tick();
        sb.wb_valid = 0;
        #1 chk("raw_after_wb", sb.id_ready, 1);
        chk("raw_busy_clr", busy, 0);
        tick();
        idle();
        #1 chk("raw_stall", stall_cycles, 2);

        // RAW on rs2, checked without letting the stall counter move.
        sb.id_valid = 1; sb.id_rd = 4; sb.id_rd_wen = 1;
        tick();
        sb.id_rd_wen = 0; sb.id_rd = 0; sb.id_rs2 = 4; sb.id_rs2_use = 1;
        #1 chk("rs2_blk", sb.id_ready, 0);
        idle();
        sb.wb_valid = 1; sb.wb_rd = 4;
        tick();
        idle();

        // WAW saturation: three writes fill x7, fourth waits for a retire.
        sb.id_valid = 1; sb.id_rd = 7; sb.id_rd_wen = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("waw_issue%0d", i), sb.id_ready, 1);
            tick();
        end
        #1 chk("waw_full", sb.id_ready, 0);
        tick();
        sb.wb_valid = 1; sb.wb_rd = 7;
        #1 chk("waw_full_same_wb", sb.id_ready, 0);
        tick();
        sb.wb_valid = 0;
        #1 chk("waw_fourth_rdy", sb.id_ready, 1);
        tick();
        sb.id_valid = 0; sb.id_rd = 0; sb.id_rd_wen = 0;
        sb.wb_valid = 1; sb.wb_rd = 7;
        repeat (3) tick();
        idle();
        #1 chk("waw_drained", busy, 0);
        chk("waw_err", err, 0);
        chk("waw_stall", stall_cycles, 4);

        // Drain: FENCE waits until nothing is outstanding, including the WB cycle.
        sb.id_valid = 1; sb.id_rd = 3; sb.id_rd_wen = 1;
        tick();
        sb.id_rd = 0; sb.id_rd_wen = 0; sb.id_drain = 1;
        #1 chk("drain_blk", sb.id_ready, 0);
        tick();
        tick();
        chk("drain_stall", stall_cycles, 6);
        sb.wb_valid = 1; sb.wb_rd = 3;
        #1 chk("drain_wb_cycle", sb.id_ready, 0);
        chk("drain_wb_busy", busy, 1);
        tick();
        sb.wb_valid = 0;
        #1 chk("drain_rdy", sb.id_ready, 1);
        chk("drain_busy_clr", busy, 0);
        tick();
        idle();
        #1 chk("drain_stall_end", stall_cycles, 7);

        // Same-cycle issue and retire of x9 leaves its count at one.
        sb.id_valid = 1; sb.id_rd = 9; sb.id_rd_wen = 1;
        tick();
        sb.wb_valid = 1; sb.wb_rd = 9;
        #1 chk("net_zero_rdy", sb.id_ready, 1);
        tick();
        idle();
        #1 chk("net_zero_busy", busy, 1);
        sb.wb_valid = 1; sb.wb_rd = 9;
        tick();
        idle();
        #1 chk("net_zero_clr", busy, 0);
        chk("net_zero_err", err, 0);

        // Spurious writeback: sticky error, counter untouched, cleared by reset.
        sb.wb_valid = 1; sb.wb_rd = 12;
        tick();
        idle();
        #1 chk("uflow_err", err, 1);
        chk("uflow_busy", busy, 0);
        tick();
        chk("uflow_err_hold", err, 1);
        reset = 1;
        tick();
        reset = 0;
        #1 chk("uflow_rst_err", err, 0);
        chk("uflow_rst_stall", stall_cycles, 0);

        // x0 traffic never hazards or counts; only the flush cycle blocks.
        sb.id_valid = 1; sb.id_rs1 = 0; sb.id_rs1_use = 1; sb.id_rd = 0; sb.id_rd_wen = 1;
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            #1 chk($sformatf("x0_rdy%0d", i), sb.id_ready, (i == 2) ? 0 : 1);
            tick();
        end
        idle();
        #1 chk("x0_busy", busy, 0);
        chk("x0_stall", stall_cycles, 1);
        chk("x0_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
